// File: rtl/common.sv
// rtl/common.sv - CBus request/response types shared by front-ends and the memory side
package common;

  localparam int CBUS_ADDR_W = 32;
  localparam int CBUS_DATA_W = 32;
  localparam int CBUS_LEN_W  = 4;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [CBUS_LEN_W-1:0]  len;
    logic [CBUS_DATA_W-1:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] rdata;
  } cbus_resp_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin pick: first set bit of valid at or after ptr, with wrap-around
module rr_select #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [N-1:0] rot;
  int           sel;

  // Rotate so ptr lands at bit 0, pick the lowest set bit, then rotate the answer back.
  always_comb begin
    rot   = '0;
    sel   = 0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j + int'(ptr) >= N) rot[j] = valid[j + int'(ptr) - N];
      else                    rot[j] = valid[j + int'(ptr)];
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
    if (sel + int'(ptr) >= N) index = IW'(sel + int'(ptr) - N);
    else                      index = IW'(sel + int'(ptr));
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// rtl/cbus_rr_arbiter.sv - burst-holding round-robin arbiter for one CBus master port, with stall watchdog
module cbus_rr_arbiter
  import common::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int TIMEOUT    = 0,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  cbus_req_t  [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0]  iresps,
  output cbus_req_t                    oreq,
  input  cbus_resp_t                   oresp,
  output logic                         busy,
  output logic       [IDX_W-1:0]       grant,
  output logic                         timeout_err
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam int WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  state_t                  state, next_state;
  logic [IDX_W-1:0]        ptr, ptr_inc, sel_index;
  logic                    sel_found;
  logic [NUM_INPUTS-1:0]   req_valid;
  logic [WD_W-1:0]         wd_cnt;
  logic                    wd_fire;

  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_INPUTS; i++) req_valid[i] = ireqs[i].valid;
  end

  rr_select #(.N(NUM_INPUTS)) u_select (
    .valid (req_valid),
    .ptr   (ptr),
    .found (sel_found),
    .index (sel_index)
  );

  assign ptr_inc = (sel_index == IDX_W'(NUM_INPUTS - 1)) ? '0 : sel_index + IDX_W'(1);

  // A ready in the threshold cycle keeps the burst alive.
  assign wd_fire = (TIMEOUT > 0) && (state == S_BUSY) && !oresp.ready &&
                   (wd_cnt == WD_W'(WD_LAST));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (sel_found) next_state = S_BUSY;
      S_BUSY: if (oresp.last || wd_fire) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr         <= '0;
      grant       <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_IDLE && sel_found) begin
        grant  <= sel_index;
        ptr    <= ptr_inc;
        wd_cnt <= '0;
      end else if (state == S_BUSY) begin
        if (oresp.ready || TIMEOUT == 0) wd_cnt <= '0;
        else                             wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_fire) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    oreq   = '0;
    iresps = '0;
    busy   = 1'b0;
    if (state == S_BUSY) begin
      busy          = 1'b1;
      oreq          = ireqs[grant];
      iresps[grant] = oresp;
    end
  end

endmodule
